cpu_instr_sequencer: RTL and testbench
======================================

// Module: cpu_instr_sequencer
// PURPOSE
//  Host-side driver for the 4-bit accumulator CPU: holds a small program (up to
//  16 instructions), then on start drives each instruction onto the CPU pin bus
//  (ui_in / uio_in) with fixed hold and settle timing, samples the CPU
//  accumulator after each one and reports it. Sits in front of the CPU on the
//  test/demo top level, replacing manual pin toggling.
// PARAMETERS
//  HOLD_CYCLES    3      cycles each instruction is held on the bus (1..15)
//  SETTLE_CYCLES  3      cycles NOP is driven after each instr before sampling (1..15)
//  NOP_OPCODE     4'hF   opcode driven when idle/settling (CPU FSM stays IDLE)
// PORTS
//  clk          in   1   clock
//  rst          in   1   asynchronous, active-high reset
//  prog_we      in   1   write program word (ignored while busy)
//  prog_addr    in   4   program slot to write
//  prog_wdata   in   13  {opcode[3:0], data[3:0], addr[3:0], we}
//  prog_len     in   5   instruction count, sampled at start; >16 clamps to 16
//  start        in   1   begin run (IDLE only)
//  stop         in   1   abort run
//  cpu_ui_in    out  8   {data, addr} to CPU ui_in
//  cpu_uio_in   out  8   {opcode, 3'b000, we} to CPU uio_in
//  cpu_acc      in   4   CPU accumulator (CPU uo_out[3:0])
//  busy         out  1   run in progress (DRIVE/SETTLE/CAPTURE)
//  pc           out  4   index of instruction being issued
//  result_valid out  1   1-cycle pulse, result_data/result_idx valid
//  result_data  out  4   sampled accumulator
//  result_idx   out  4   instruction index of result
//  done         out  1   1-cycle pulse, run completed normally
//  aborted      out  1   1-cycle pulse, run terminated by stop
// BEHAVIOUR
//  - Reset: state IDLE, pc=0, counters=0, all pulses 0, result_data/idx=0,
//    cpu_ui_in=8'h00, cpu_uio_in={NOP_OPCODE,4'b0000}, all 16 program words =
//    {NOP_OPCODE,4'h0,4'h0,1'b0}. All outputs registered.
//  - Program write: prog_we && !busy writes prog_wdata to slot prog_addr at edge.
//  - FSM: IDLE -> DRIVE -> SETTLE -> CAPTURE -> (DRIVE | DONE) -> IDLE; ABORT->IDLE.
//  - IDLE: drive NOP bus; start (without stop) latches len=min(prog_len,16), pc=0;
//    len==0 -> DONE, else -> DRIVE.
//  - DRIVE: bus = prog[pc] ({data,addr} / {opcode,000,we}) for exactly
//    HOLD_CYCLES cycles, then SETTLE.
//  - SETTLE: NOP bus for exactly SETTLE_CYCLES cycles; on leaving edge cpu_acc is
//    registered into result_data, result_idx=pc.
//  - CAPTURE: 1 cycle, result_valid=1, NOP bus; if pc==len-1 -> DONE else pc+1,
//    -> DRIVE.
//  - DONE: done=1 for 1 cycle, NOP bus, -> IDLE; pc holds last index.
//  - Per-instruction cost HOLD+SETTLE+1 cycles; with start sampled at edge 0,
//    done is high in cycle 1+len*(HOLD+SETTLE+1).
//  - stop: in DRIVE/SETTLE/CAPTURE -> ABORT next edge (NOP bus immediately,
//    aborted=1 one cycle, no further result_valid; a result_valid in the same
//    CAPTURE cycle stands), then IDLE. stop in IDLE/DONE ignored;
//    start&&stop in IDLE: stop wins, stays IDLE.
//  - start while busy ignored; prog_we while busy ignored (program protected).
//  - Async rst mid-run: immediate return to reset values incl. program cleared.
// TESTING
//  - Load 3 words {3,x,5,0},{0,4'h2,0,0},{2,0,7,1}, len=3, start -> bus shows each
//    word 3 cycles then NOP 3; result_valid at idx 0,1,2 matching cpu_acc; done
//    in cycle 22.
//  - prog_len=0, start -> done in cycle 1, busy never 1, no result_valid.
//  - prog_len=20 with 16 slots loaded -> 16 results, idx 0..15, pc never wraps.
//  - stop during DRIVE of pc=1 -> NOP bus next cycle, aborted pulse, busy=0, only
//    result idx 0 reported; start and stop together in IDLE -> no run.
//  - prog_we to slot 0 while busy -> ignored; rerun shows original word 0.
//  - rst asserted during SETTLE -> outputs at reset values asynchronously, rerun
//    after reset drives NOP words only.

Source files
------------

// File: rtl/cpu_instr_sequencer.sv
// Host-side sequencer for the 4-bit accumulator CPU: stores up to 16 instruction
// words and replays them onto the CPU pin bus with fixed hold/settle timing.
module cpu_instr_sequencer #(
  parameter int unsigned HOLD_CYCLES   = 3,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter logic [3:0]  NOP_OPCODE    = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [12:0] prog_wdata,
  input  logic [4:0]  prog_len,
  input  logic        start,
  input  logic        stop,
  output logic [7:0]  cpu_ui_in,
  output logic [7:0]  cpu_uio_in,
  input  logic [3:0]  cpu_acc,
  output logic        busy,
  output logic [3:0]  pc,
  output logic        result_valid,
  output logic [3:0]  result_data,
  output logic [3:0]  result_idx,
  output logic        done,
  output logic        aborted
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DRIVE   = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ABORT   = 3'd5;

  localparam logic [3:0]  HOLD_LAST   = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [12:0] NOP_WORD    = {NOP_OPCODE, 8'h00, 1'b0};
  localparam logic [7:0]  NOP_UIO     = {NOP_OPCODE, 4'b0000};

  logic [12:0] prog [16];

  logic [2:0]  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  pc_nxt;
  logic [4:0]  len, len_nxt;
  logic        load_bus;
  logic [12:0] bus_word;
  logic [7:0]  ui_nxt, uio_nxt;
  logic        busy_nxt, valid_nxt, done_nxt, aborted_nxt;
  logic [3:0]  rdata_nxt, ridx_nxt;

  // Program store; writes are locked out while a run is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) prog[i] <= NOP_WORD;
    end else if (prog_we && !busy) begin
      prog[prog_addr] <= prog_wdata;
    end
  end

  // Next-state logic; every output is computed here and registered below.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pc_nxt      = pc;
    len_nxt     = len;
    load_bus    = 1'b0;
    valid_nxt   = 1'b0;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    rdata_nxt   = result_data;
    ridx_nxt    = result_idx;

    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          len_nxt = (prog_len > 5'd16) ? 5'd16 : prog_len;
          pc_nxt  = 4'd0;
          cnt_nxt = 4'd0;
          if (prog_len == 5'd0) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_DRIVE;
            load_bus  = 1'b1;
          end
        end
      end
      S_DRIVE: begin
        if (stop) begin
          state_nxt   = S_ABORT;
          aborted_nxt = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt  = cnt + 4'd1;
          load_bus = 1'b1;
        end
      end
      S_SETTLE: begin
        if (stop) begin
          state_nxt   = S_ABORT;
          aborted_nxt = 1'b1;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = S_CAPTURE;
          cnt_nxt   = 4'd0;
          rdata_nxt = cpu_acc;
          ridx_nxt  = pc;
          valid_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_CAPTURE: begin
        if (stop) begin
          state_nxt   = S_ABORT;
          aborted_nxt = 1'b1;
        end else if ({1'b0, pc} == len - 5'd1) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else begin
          pc_nxt    = pc + 4'd1;
          state_nxt = S_DRIVE;
          load_bus  = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ABORT: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    bus_word = prog[pc_nxt];
    if (load_bus) begin
      ui_nxt  = {bus_word[8:5], bus_word[4:1]};
      uio_nxt = {bus_word[12:9], 3'b000, bus_word[0]};
    end else begin
      ui_nxt  = 8'h00;
      uio_nxt = NOP_UIO;
    end

    busy_nxt = (state_nxt == S_DRIVE) || (state_nxt == S_SETTLE) ||
               (state_nxt == S_CAPTURE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      pc           <= 4'd0;
      len          <= 5'd0;
      cpu_ui_in    <= 8'h00;
      cpu_uio_in   <= NOP_UIO;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= 4'd0;
      result_idx   <= 4'd0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pc           <= pc_nxt;
      len          <= len_nxt;
      cpu_ui_in    <= ui_nxt;
      cpu_uio_in   <= uio_nxt;
      busy         <= busy_nxt;
      result_valid <= valid_nxt;
      result_data  <= rdata_nxt;
      result_idx   <= ridx_nxt;
      done         <= done_nxt;
      aborted      <= aborted_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Randomized bench for cpu_instr_sequencer: a timeline model predicts the bus,
// strobes and results for every cycle of a run from the slot/phase arithmetic.
module tb_cpu_instr_sequencer;

  localparam logic [12:0] NOP_W = {4'hF, 8'h00, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [12:0] prog_wdata;
  logic [4:0]  prog_len;
  logic        start;
  logic        stop;
  logic [7:0]  cpu_ui_in;
  logic [7:0]  cpu_uio_in;
  logic [3:0]  cpu_acc;
  logic        busy;
  logic [3:0]  pc;
  logic        result_valid;
  logic [3:0]  result_data;
  logic [3:0]  result_idx;
  logic        done;
  logic        aborted;

  int n_cmp = 0;
  int n_bad = 0;
  logic [12:0] exp_prog [16];

  cpu_instr_sequencer dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .start(start), .stop(stop),
    .cpu_ui_in(cpu_ui_in), .cpu_uio_in(cpu_uio_in), .cpu_acc(cpu_acc),
    .busy(busy), .pc(pc), .result_valid(result_valid),
    .result_data(result_data), .result_idx(result_idx), .done(done),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  // Bus image of a program word plus the four status strobes.
  function automatic logic [19:0] bus_vec(input logic [12:0] w, input logic b,
                                          input logic rv, input logic dn,
                                          input logic ab);
    return {w[8:5], w[4:1], w[12:9], 3'b000, w[0], b, rv, dn, ab};
  endfunction

  task automatic load_word(input int addr, input logic [12:0] w);
    prog_we    = 1'b1;
    prog_addr  = 4'(addr);
    prog_wdata = w;
    @(posedge clk); #1;
    prog_we    = 1'b0;
    exp_prog[addr] = w;
  endtask

  // Starts a run and checks every cycle against the timeline model. Optional
  // events: stop at period stop_at, a protected write at we_at, reset at rst_at.
  task automatic applyStimulus(input string name, input int len_in,
                               input int stop_at, input int we_at,
                               input int rst_at);
    int L, n, last_t, slot, ph;
    logic [19:0] exp_v, obs_v;
    logic [3:0]  exp_pc;
    logic        chk_pc;
    L = (len_in > 16) ? 16 : len_in;
    n = L * 7;
    last_t = (stop_at >= 0) ? stop_at + 2 : n + 1;
    prog_len = 5'(len_in);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t <= last_t; t++) begin
      chk_pc = 1'b0;
      exp_pc = 4'd0;
      if (stop_at >= 0 && t == stop_at + 1) begin
        exp_v = bus_vec(NOP_W, 1'b0, 1'b0, 1'b0, 1'b1);
      end else if (stop_at >= 0 && t == stop_at + 2) begin
        exp_v = bus_vec(NOP_W, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (t < n) begin
        slot = t / 7;
        ph   = t % 7;
        exp_v = bus_vec((ph < 3) ? exp_prog[slot] : NOP_W, 1'b1, ph == 6,
                        1'b0, 1'b0);
        exp_pc = 4'(slot);
        chk_pc = 1'b1;
        if (ph == 6) begin
          n_cmp++;
          if (result_idx !== 4'(slot) || result_data !== cpu_acc) begin
            n_bad++;
            $display("[TB] FAIL %s result t=%0d: got idx=%0d data=%h, need idx=%0d data=%h",
                     name, t, result_idx, result_data, slot, cpu_acc);
          end
        end
      end else if (t == n) begin
        exp_v = bus_vec(NOP_W, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_pc = (L > 0) ? 4'(L - 1) : 4'd0;
        chk_pc = 1'b1;
      end else begin
        exp_v = bus_vec(NOP_W, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      obs_v = {cpu_ui_in, cpu_uio_in, busy, result_valid, done, aborted};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++;
        $display("[TB] FAIL %s bus/strobes t=%0d: got %h, need %h", name, t, obs_v, exp_v);
      end
      if (chk_pc) begin
        n_cmp++;
        if (pc !== exp_pc) begin
          n_bad++;
          $display("[TB] FAIL %s pc t=%0d: got %0d, need %0d", name, t, pc, exp_pc);
        end
      end
      if (t == rst_at) begin
        #2 rst = 1'b1;
        #1;
        obs_v = {cpu_ui_in, cpu_uio_in, busy, result_valid, done, aborted};
        n_cmp++;
        if (obs_v !== bus_vec(NOP_W, 1'b0, 1'b0, 1'b0, 1'b0) || pc !== 4'd0 ||
            result_data !== 4'd0 || result_idx !== 4'd0) begin
          n_bad++;
          $display("[TB] FAIL %s async reset: got %h pc=%0d rd=%h ri=%0d, need %h pc=0 rd=0 ri=0",
                   name, obs_v, pc, result_data, result_idx,
                   bus_vec(NOP_W, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 16; i++) exp_prog[i] = NOP_W;
        @(posedge clk); #1;
        break;
      end
      if (t == stop_at) stop = 1'b1;
      if (t == stop_at + 1) stop = 1'b0;
      if (t == we_at) begin
        prog_we    = 1'b1;
        prog_addr  = 4'd0;
        prog_wdata = ~exp_prog[0];
      end
      if (t == we_at + 1) prog_we = 1'b0;
      cpu_acc = 4'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    logic [19:0] obs_v;
    #3;
    obs_v = {cpu_ui_in, cpu_uio_in, busy, result_valid, done, aborted};
    n_cmp++;
    if (obs_v !== bus_vec(NOP_W, 1'b0, 1'b0, 1'b0, 1'b0) || pc !== 4'd0 ||
        result_data !== 4'd0 || result_idx !== 4'd0) begin
      n_bad++;
      $display("[TB] FAIL reset values: got %h pc=%0d rd=%h ri=%0d", obs_v, pc,
               result_data, result_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_program();
    load_word(0, {4'd3, 4'($urandom), 4'd5, 1'b0});
    load_word(1, {4'd0, 4'h2, 4'd0, 1'b0});
    load_word(2, {4'd2, 4'd0, 4'd7, 1'b1});
    applyStimulus("basic3", 3, -10, -10, -10);
  endtask

  task automatic test_zero_len();
    applyStimulus("len0", 0, -10, -10, -10);
  endtask

  task automatic test_random_programs();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) load_word(i, 13'($urandom));
      applyStimulus("random", int'($urandom_range(1, 16)), -10, -10, -10);
    end
    applyStimulus("len20", 20, -10, -10, -10);
  endtask

  task automatic test_stop();
    logic [19:0] obs_v;
    for (int i = 0; i < 4; i++) load_word(i, 13'($urandom));
    applyStimulus("stop_pc1", 4, 8, -10, -10);
    prog_len = 5'd3;
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    for (int t = 0; t < 3; t++) begin
      obs_v = {cpu_ui_in, cpu_uio_in, busy, result_valid, done, aborted};
      n_cmp++;
      if (obs_v !== bus_vec(NOP_W, 1'b0, 1'b0, 1'b0, 1'b0)) begin
        n_bad++;
        $display("[TB] FAIL start_and_stop t=%0d: got %h, need %h", t, obs_v,
                 bus_vec(NOP_W, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_prog_protect();
    load_word(0, 13'($urandom));
    applyStimulus("protect_run", 1, -10, 1, -10);
    applyStimulus("protect_rerun", 1, -10, -10, -10);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) load_word(i, 13'($urandom));
    applyStimulus("rst_settle", 3, -10, -10, 4);
    applyStimulus("after_rst", 3, -10, -10, -10);
  endtask

  initial begin
    rst        = 1'b1;
    prog_we    = 1'b0;
    prog_addr  = 4'd0;
    prog_wdata = 13'd0;
    prog_len   = 5'd0;
    start      = 1'b0;
    stop       = 1'b0;
    cpu_acc    = 4'd0;
    for (int i = 0; i < 16; i++) exp_prog[i] = NOP_W;
    test_reset();
    test_basic_program();
    test_zero_len();
    test_random_programs();
    test_stop();
    test_prog_protect();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
